logic_unit_pipe: RTL

- Parametrised, pipelined bitwise logic unit; next generation of the fixed-width 16-bit XOR slice in the MIPS25 ALU datapath.
- Generalises width and adds an 8-function op select, result flags, configurable pipeline depth and valid/ready flow control with backpressure.
- Feeds the ALU result mux; the downstream writeback stage may stall it.

---
 rtl/logic_unit_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with result flags, elastic valid/ready stages
// and collapsing bubbles. Latency equals STAGES; throughput one per cycle.
module logic_unit_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clkpos1,
  input  logic             rstneg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Cout,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] zf;
  logic [STAGES-1:0] pf;
  logic [WIDTH-1:0]  dat [STAGES];

  logic [WIDTH-1:0]  res_c;
  logic              zero_c;
  logic              parity_c;
  logic              accept_c;

  // Bitwise function and flags of the presented operand set
  always_comb begin
    res_c = '0;
    unique case (op)
      3'b000: res_c = A & B;
      3'b001: res_c = A | B;
      3'b010: res_c = A ^ B;
      3'b011: res_c = ~(A ^ B);
      3'b100: res_c = ~(A & B);
      3'b101: res_c = ~(A | B);
      3'b110: res_c = A;
      default: res_c = ~A;
    endcase
    zero_c   = (res_c == '0);
    parity_c = ^res_c;
  end

  // Ready ripples back from the output: a stage moves when the next one can load
  always_comb begin
    adv = '0;
    load = '0;
    adv[LAST]  = vld[LAST] & out_ready;
    load[LAST] = ~vld[LAST] | adv[LAST];
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      adv[k]  = vld[k] & load[k+1];
      load[k] = ~vld[k] | adv[k];
    end
  end

  assign in_ready = rstneg & load[0];
  assign accept_c = in_valid & in_ready;

  // Stage registers: stage 0 captures on accept, later stages take from upstream
  always_ff @(posedge clkpos1 or negedge rstneg) begin
    if (!rstneg) begin
      vld <= '0;
      zf  <= '0;
      pf  <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        dat[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld[0] <= in_valid;
      end
      if (accept_c) begin
        dat[0] <= res_c;
        zf[0]  <= zero_c;
        pf[0]  <= parity_c;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (load[k]) begin
          vld[k] <= adv[k-1];
        end
        if (adv[k-1]) begin
          dat[k] <= dat[k-1];
          zf[k]  <= zf[k-1];
          pf[k]  <= pf[k-1];
        end
      end
    end
  end

  assign out_valid = vld[LAST];
  assign Cout      = dat[LAST];
  assign zero      = zf[LAST];
  assign parity    = pf[LAST];
  assign busy      = |vld;

endmodule
